dmem_arbiter: RTL and testbench

- Two-requester arbiter that shares the single-port 256x8 data memory between the CPU load/store unit (port A) and the program/debug loader (port B).
- Sits between both requesters and the data memory's addr/we/din/dout pins.
- Sequences one memory access per cycle, grants round-robin with bounded bursts, and returns read data registered one cycle after grant.

---
 rtl/dmem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory.
// Optional stall counter enabled by DMEM_ARB_CONFLICT_CNT_EN.
module dmem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_din,
`ifdef DMEM_ARB_CONFLICT_CNT_EN
  output logic [15:0]   conflict_cnt,
`endif
  input  logic [DW-1:0] mem_dout
);

  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_e;

  state_e          state_q, state_d;
  logic            last_b_q, last_b_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic            a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [DW-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_din_q, mem_din_d;
  logic            grant_a, grant_b;
  logic [BW-1:0]   burst_inc;

  // Saturating increment used while the current owner keeps the memory.
  assign burst_inc = (burst_q == BW'(MAX_BURST)) ? burst_q : burst_q + 1'b1;

  always_comb begin
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    state_d  = state_q;
    last_b_d = last_b_q;
    burst_d  = burst_q;
    unique case (state_q)
      IDLE: begin
        if (a_req && (!b_req || last_b_q)) grant_a = 1'b1;
        else if (b_req)                    grant_b = 1'b1;
      end
      OWN_A: begin
        if (a_req && (!b_req || burst_q < BW'(MAX_BURST))) grant_a = 1'b1;
        else if (b_req)                                    grant_b = 1'b1;
      end
      OWN_B: begin
        if (b_req && (!a_req || burst_q < BW'(MAX_BURST))) grant_b = 1'b1;
        else if (a_req)                                    grant_a = 1'b1;
      end
      default: ;
    endcase
    if (grant_a) begin
      state_d  = OWN_A;
      last_b_d = 1'b0;
      burst_d  = (state_q == OWN_A) ? burst_inc : BW'(1);
    end else if (grant_b) begin
      state_d  = OWN_B;
      last_b_d = 1'b1;
      burst_d  = (state_q == OWN_B) ? burst_inc : BW'(1);
    end else begin
      state_d  = IDLE;
      burst_d  = '0;
    end
  end

  // Nothing reaches the memory while reset is held.
  assign a_gnt = grant_a & ~rst;
  assign b_gnt = grant_b & ~rst;

  always_comb begin
    mem_addr = mem_addr_q;
    mem_din  = mem_din_q;
    mem_we   = 1'b0;
    if (a_gnt) begin
      mem_addr = a_addr;
      mem_din  = a_wdata;
      mem_we   = a_we;
    end else if (b_gnt) begin
      mem_addr = b_addr;
      mem_din  = b_wdata;
      mem_we   = b_we;
    end
    mem_addr_d = mem_addr;
    mem_din_d  = mem_din;
  end

  always_comb begin
    a_rvalid_d = a_gnt & ~a_we;
    b_rvalid_d = b_gnt & ~b_we;
    a_rdata_d  = a_rvalid_d ? mem_dout : a_rdata_q;
    b_rdata_d  = b_rvalid_d ? mem_dout : b_rdata_q;
  end

  // A read captured just before reset must not leak out during the reset cycle.
  assign a_rvalid = a_rvalid_q & ~rst;
  assign b_rvalid = b_rvalid_q & ~rst;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_b_q   <= 1'b1;
      burst_q    <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_b_q   <= last_b_d;
      burst_q    <= burst_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
    end
  end

`ifdef DMEM_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  // With both requesting, exactly one is always stalled.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (a_req && b_req && !(a_gnt && b_gnt) && conflict_cnt_q != 16'hFFFF)
      conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) conflict_cnt_q <= '0;
    else     conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256x8 memory.
module tb_dmem_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic [7:0] mem_addr, mem_din, mem_dout;
  logic       mem_we;
`ifdef DMEM_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  logic [7:0] mem [256];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
`ifdef DMEM_ARB_CONFLICT_CNT_EN
    .conflict_cnt(conflict_cnt),
`endif
    .mem_dout(mem_dout)
  );

  assign mem_dout = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wd);
    a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
  endtask

  task automatic drv_b(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wd);
    b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
  endtask

  // Grant owner per cycle with both requesting from IDLE: A x4, B x4, A x2.
  localparam logic [9:0] EXP_A = 10'b1100001111;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst = 1'b1;
    drv_a(0, 0, 8'h00, 8'h00);
    drv_b(0, 0, 8'h00, 8'h00);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_a_gnt",    32'(a_gnt),    32'd0);
    chk("rst_b_gnt",    32'(b_gnt),    32'd0);
    chk("rst_mem_we",   32'(mem_we),   32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
    chk("rst_a_rdata",  32'(a_rdata),  32'd0);
    chk("rst_b_rdata",  32'(b_rdata),  32'd0);

    // A write, then idle cycle must hold mem_addr
    drv_a(1, 1, 8'h10, 8'h5A); #1;
    chk("wr_a_gnt",    32'(a_gnt),    32'd1);
    chk("wr_b_gnt",    32'(b_gnt),    32'd0);
    chk("wr_mem_we",   32'(mem_we),   32'd1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h10);
    chk("wr_mem_din",  32'(mem_din),  32'h5A);
    tick();
    drv_a(0, 0, 8'h00, 8'h00); #1;
    chk("wr_no_rvalid", 32'(a_rvalid), 32'd0);
    chk("idle_we",      32'(mem_we),   32'd0);
    chk("idle_hold",    32'(mem_addr), 32'h10);
    tick();

    // A read back
    drv_a(1, 0, 8'h10, 8'h00); #1;
    chk("rd_a_gnt",  32'(a_gnt),  32'd1);
    chk("rd_mem_we", 32'(mem_we), 32'd0);
    tick();
    drv_a(0, 0, 8'h00, 8'h00); #1;
    chk("rd_a_rvalid", 32'(a_rvalid), 32'd1);
    chk("rd_a_rdata",  32'(a_rdata),  32'h5A);
    tick();
    chk("rd_rvalid_pulse", 32'(a_rvalid), 32'd0);
    chk("rd_rdata_hold",   32'(a_rdata),  32'h5A);

    // B write while A idle, gap to IDLE, then simultaneous requests
    drv_b(1, 1, 8'h20, 8'hC3); #1;
    chk("bwr_b_gnt",    32'(b_gnt),    32'd1);
    chk("bwr_a_gnt",    32'(a_gnt),    32'd0);
    chk("bwr_mem_addr", 32'(mem_addr), 32'h20);
    chk("bwr_mem_din",  32'(mem_din),  32'hC3);
    tick();
    drv_b(0, 0, 8'h00, 8'h00);
    tick();
    drv_a(1, 0, 8'h10, 8'h00);
    drv_b(1, 0, 8'h20, 8'h00); #1;
    chk("tie_a_gnt", 32'(a_gnt), 32'd1);
    chk("tie_b_gnt", 32'(b_gnt), 32'd0);
    tick();
    drv_a(0, 0, 8'h00, 8'h00); #1;
    chk("tie_b_next",   32'(b_gnt),    32'd1);
    chk("tie_a_rvalid", 32'(a_rvalid), 32'd1);
    chk("tie_a_rdata",  32'(a_rdata),  32'h5A);
    tick();
    drv_b(0, 0, 8'h00, 8'h00); #1;
    chk("tie_b_rvalid", 32'(b_rvalid), 32'd1);
    chk("tie_b_rdata",  32'(b_rdata),  32'hC3);
    tick();

    // Bounded bursts from reset with both reading continuously
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drv_a(1, 0, 8'h10, 8'h00);
    drv_b(1, 0, 8'h20, 8'h00);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("burst_a_gnt%0d", i), 32'(a_gnt), 32'(EXP_A[i]));
      chk($sformatf("burst_b_gnt%0d", i), 32'(b_gnt), 32'(!EXP_A[i]));
      tick();
      chk($sformatf("burst_a_rv%0d", i), 32'(a_rvalid), 32'(EXP_A[i]));
      chk($sformatf("burst_b_rv%0d", i), 32'(b_rvalid), 32'(!EXP_A[i]));
      if (EXP_A[i]) chk($sformatf("burst_a_rd%0d", i), 32'(a_rdata), 32'h5A);
      else          chk($sformatf("burst_b_rd%0d", i), 32'(b_rdata), 32'hC3);
    end
`ifdef DMEM_ARB_CONFLICT_CNT_EN
    chk("conflict_10", 32'(conflict_cnt), 32'd10);
`endif
    drv_a(0, 0, 8'h00, 8'h00);
    drv_b(0, 0, 8'h00, 8'h00);
    tick();

    // Reset right after a B read grant; write attempt during reset
    drv_b(1, 0, 8'h20, 8'h00); #1;
    chk("rr_b_gnt", 32'(b_gnt), 32'd1);
    tick();
    rst = 1'b1;
    drv_b(0, 0, 8'h00, 8'h00);
    drv_a(1, 1, 8'h33, 8'h77); #1;
    chk("rr_b_rvalid_in_rst", 32'(b_rvalid), 32'd0);
    chk("rr_a_gnt_in_rst",    32'(a_gnt),    32'd0);
    chk("rr_we_in_rst",       32'(mem_we),   32'd0);
    tick();
    rst = 1'b0;
    drv_a(0, 0, 8'h00, 8'h00); #1;
    chk("rr_b_rvalid", 32'(b_rvalid), 32'd0);
    chk("rr_b_rdata",  32'(b_rdata),  32'd0);
    chk("rr_b_gnt",    32'(b_gnt),    32'd0);
    chk("rr_no_write", 32'(mem[8'h33]), 32'd0);

`ifdef DMEM_ARB_CONFLICT_CNT_EN
    chk("conflict_rst", 32'(conflict_cnt), 32'd0);
    drv_a(1, 0, 8'h10, 8'h00);
    drv_b(1, 0, 8'h20, 8'h00);
    force dut.conflict_cnt_q = 16'hFFFE;
    #1;
    release dut.conflict_cnt_q;
    tick(); tick(); tick();
    chk("conflict_sat", 32'(conflict_cnt), 32'hFFFF);
    drv_a(0, 0, 8'h00, 8'h00);
    drv_b(0, 0, 8'h00, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
